// File: rtl/mem_rw_rsp.sv
// Single-port memory responder: clears its array after reset, then serves
// read/write requests with fixed-latency read data, error flags and refresh.
module mem_rw_rsp #(
    parameter int AW          = 8,
    parameter int DW          = 32,
    parameter int WORDS       = 256,
    parameter int LATENCY     = 1,
    parameter int REFR_PERIOD = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          read,
    input  logic          write,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          inj_serr,
    input  logic          inj_derr,
    output logic          read_vld,
    output logic          read_serr,
    output logic          read_derr,
    output logic [DW-1:0] dout,
    output logic          ready,
    output logic          refr,
    output logic          drop
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [AW:0] WORDS_C = (AW + 1)'(WORDS);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] init_cnt;
    logic [DW-1:0] mem [WORDS];

    logic          req, acc, in_range, init_last;
    logic          s0_vld, s0_serr, s0_derr;
    logic [DW-1:0] s0_data;

    assign req       = read | write;
    assign acc       = rst & (state_q == RUN) & ~refr & req;
    assign in_range  = {1'b0, addr} < WORDS_C;
    assign init_last = init_cnt == IW'(WORDS - 1);
    assign ready     = state_q == RUN;
    assign s0_vld    = acc & read;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    if (init_last) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= INIT;
            init_cnt <= '0;
            drop     <= 1'b0;
        end else begin
            state_q  <= state_d;
            init_cnt <= (state_q == INIT && !init_last) ? init_cnt + 1'b1 : '0;
            drop     <= req & ~acc;
        end
    end

    // No reset on the array itself; INIT walks it to zero instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == INIT)
                mem[init_cnt] <= '0;
            else if (acc && write && in_range)
                mem[addr[IW-1:0]] <= din;
        end
    end

    always_comb begin
        s0_data = '0;
        s0_serr = 1'b0;
        s0_derr = 1'b0;
        if (s0_vld) begin
            if (!in_range) begin
                s0_derr = 1'b1;
            end else begin
                s0_data    = mem[addr[IW-1:0]];
                s0_data[0] = s0_data[0] ^ inj_derr;
                s0_derr    = inj_derr;
                s0_serr    = inj_serr & ~inj_derr;
            end
        end
    end

    generate
        if (REFR_PERIOD > 0) begin : g_refr
            localparam int RW = (REFR_PERIOD > 1) ? $clog2(REFR_PERIOD) : 1;
            logic [RW-1:0] rcnt;
            logic          rlast;

            assign rlast = rcnt == RW'(REFR_PERIOD - 1);
            assign refr  = (state_q == RUN) & rlast;

            always_ff @(posedge clk) begin
                if (!rst || state_q != RUN)
                    rcnt <= '0;
                else
                    rcnt <= rlast ? '0 : rcnt + 1'b1;
            end
        end else begin : g_norefr
            assign refr = 1'b0;
        end

        if (LATENCY == 0) begin : g_comb
            logic [DW-1:0] hold_q;

            always_ff @(posedge clk) begin
                if (!rst)
                    hold_q <= '0;
                else if (s0_vld)
                    hold_q <= s0_data;
            end

            assign read_vld  = s0_vld;
            assign read_serr = s0_serr;
            assign read_derr = s0_derr;
            assign dout      = s0_vld ? s0_data : hold_q;
        end else begin : g_pipe
            logic [LATENCY-1:0] vld_p, serr_p, derr_p;
            logic [DW-1:0]      data_p [LATENCY];

            // Data stages only load on a valid beat so the tail holds dout.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    vld_p  <= '0;
                    serr_p <= '0;
                    derr_p <= '0;
                    for (int i = 0; i < LATENCY; i++)
                        data_p[i] <= '0;
                end else begin
                    vld_p[0]  <= s0_vld;
                    serr_p[0] <= s0_serr;
                    derr_p[0] <= s0_derr;
                    if (s0_vld)
                        data_p[0] <= s0_data;
                    for (int i = 1; i < LATENCY; i++) begin
                        vld_p[i]  <= vld_p[i-1];
                        serr_p[i] <= serr_p[i-1];
                        derr_p[i] <= derr_p[i-1];
                        if (vld_p[i-1])
                            data_p[i] <= data_p[i-1];
                    end
                end
            end

            assign read_vld  = vld_p[LATENCY-1];
            assign read_serr = serr_p[LATENCY-1];
            assign read_derr = derr_p[LATENCY-1];
            assign dout      = data_p[LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_mem_rw_rsp.sv
// Bench for mem_rw_rsp: two instances (LATENCY 3 and 0, refresh 16, AW 9)
// share one stimulus stream and one cycle-level reference model.
module tb_mem_rw_rsp;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int WORDS = 256;
    localparam int RP    = 16;
    localparam int HMAX  = 8192;

    typedef struct packed {
        logic          vld;
        logic          serr;
        logic          derr;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic          inj_serr = 1'b0;
    logic          inj_derr = 1'b0;

    logic [1:0]    o_vld, o_serr, o_derr, o_ready, o_refr, o_drop;
    logic [DW-1:0] o_dout [2];

    mem_rw_rsp #(
        .AW(AW), .DW(DW), .WORDS(WORDS), .LATENCY(3), .REFR_PERIOD(RP)
    ) u_lat3 (
        .clk(clk), .rst(rst), .read(read), .write(write),
        .addr(addr), .din(din), .inj_serr(inj_serr), .inj_derr(inj_derr),
        .read_vld(o_vld[0]), .read_serr(o_serr[0]), .read_derr(o_derr[0]),
        .dout(o_dout[0]), .ready(o_ready[0]), .refr(o_refr[0]),
        .drop(o_drop[0])
    );

    mem_rw_rsp #(
        .AW(AW), .DW(DW), .WORDS(WORDS), .LATENCY(0), .REFR_PERIOD(RP)
    ) u_lat0 (
        .clk(clk), .rst(rst), .read(read), .write(write),
        .addr(addr), .din(din), .inj_serr(inj_serr), .inj_derr(inj_derr),
        .read_vld(o_vld[1]), .read_serr(o_serr[1]), .read_derr(o_derr[1]),
        .dout(o_dout[1]), .ready(o_ready[1]), .refr(o_refr[1]),
        .drop(o_drop[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    rsp_t          hist [HMAX];
    logic [DW-1:0] mref [WORDS];
    logic [DW-1:0] last_dout [2];
    int            age, cyc, last_rst;
    logic          drop_m;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h",
                     tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive, predict, compare, then advance the model.
    task automatic step(input logic r_n, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic is, input logic id);
        logic rdy, rf, acc;
        rsp_t r, e;
        int   src, lat;
        @(negedge clk);
        rst = r_n; read = rd; write = wr; addr = a; din = d;
        inj_serr = is; inj_derr = id;
        rdy = age >= WORDS;
        rf  = rdy && ((age - WORDS) % RP == RP - 1);
        acc = r_n && rdy && !rf && (rd || wr);
        r   = '0;
        if (acc && rd) begin
            r.vld = 1'b1;
            if (a >= WORDS) begin
                r.derr = 1'b1;
            end else if (id) begin
                r.data = mref[a] ^ 32'd1;
                r.derr = 1'b1;
            end else begin
                r.data = mref[a];
                r.serr = is;
            end
        end
        hist[cyc] = r;
        #1;
        if (r_n) begin
            check("ready", 64'(o_ready), 64'({2{rdy}}));
            check("refr", 64'(o_refr), 64'({2{rf}}));
            check("drop", 64'(o_drop), 64'({2{drop_m}}));
            for (int i = 0; i < 2; i++) begin
                lat = (i == 0) ? 3 : 0;
                src = cyc - lat;
                e = '0;
                e.data = last_dout[i];
                if (src > last_rst && hist[src].vld)
                    e = hist[src];
                check(i == 0 ? "rsp_lat3" : "rsp_lat0",
                      64'({o_vld[i], o_serr[i], o_derr[i], o_dout[i]}),
                      64'(e));
                if (e.vld)
                    last_dout[i] = e.data;
            end
        end
        if (!r_n) begin
            age = 0;
            last_rst = cyc;
            drop_m = 1'b0;
            last_dout = '{default: '0};
            foreach (mref[k]) mref[k] = '0;
        end else begin
            drop_m = (rd || wr) && !acc;
            if (acc && wr && a < WORDS)
                mref[a] = d;
            age++;
        end
        cyc++;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic rand_step();
        logic rd, wr, is, id;
        logic [AW-1:0] a;
        rd = $urandom_range(0, 99) < 60;
        wr = $urandom_range(0, 99) < 40;
        is = $urandom_range(0, 9) == 0;
        id = $urandom_range(0, 9) == 0;
        if ($urandom_range(0, 9) == 0)
            a = AW'($urandom_range(250, 300));
        else
            a = AW'($urandom_range(0, 15));
        if (a >= WORDS) begin
            is = 1'b0;
            id = 1'b0;
        end
        step(1'b1, rd, wr, a, $urandom, is, id);
    endtask

    initial begin
        age = 0;
        cyc = 0;
        last_rst = 0;
        drop_m = 1'b0;
        last_dout = '{default: '0};
        foreach (mref[k]) mref[k] = '0;

        repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (WORDS + 4) rand_step();

        step(1'b1, 1'b1, 1'b0, 9'h010, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 1'b0, 1'b0);
        repeat (9) step(1'b1, 1'b1, 1'b0, 9'h005, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 9'h007, 32'h11, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 9'h007, 32'h22, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 9'h007, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 9'h007, '0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 9'h007, '0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 9'h007, '0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 9'h100, '0, 1'b0, 1'b0);
        repeat (6) idle();

        repeat (2000) rand_step();

        step(1'b1, 1'b1, 1'b0, 9'h005, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 9'h007, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (WORDS + 40) rand_step();
        repeat (10) idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_rw_rsp.md
# mem_rw_rsp

Synthesizable single-port memory responder: the memory-side end of the single-port read/write memory interface that testbench initiators drive through their request clocking blocks. It accepts read/write requests, returns read data after a fixed LATENCY with valid and ECC-style error flags, clears its array after reset, and drives the ready/refresh status signals. It serves as the stand-in memory behind packed multi-port interfaces and for loopback tests of bench drivers.

## Interface
- AW, 8, address width
- DW, 32, data width
- WORDS, 256, array depth; legal addresses 0..WORDS-1; WORDS <= 2**AW
- LATENCY, 1, read latency in cycles; legal range 0..30
- REFR_PERIOD, 0, refresh interval in cycles; 0 disables refresh
- clk  input  1  clock; all state on posedge
- rst  input  1  reset, synchronous, active-low
- read  input  1  read request
- write  input  1  write request
- addr  input  AW  request address
- din  input  DW  write data
- inj_serr  input  1  inject single-bit error on this read
- inj_derr  input  1  inject double-bit error on this read
- read_vld  output  1  read data valid
- read_serr  output  1  corrected error on returned data
- read_derr  output  1  uncorrectable error on returned data
- dout  output  DW  read data
- ready  output  1  initialization done; requests accepted
- refr  output  1  refresh cycle; requests ignored
- drop  output  1  one-cycle pulse: request ignored (INIT or refr)

## Operation
- States: INIT, RUN. Reset (rst=0) forces INIT with init counter = 0.
- INIT: one word cleared to 0 per cycle, counter 0..WORDS-1; after word WORDS-1 -> RUN. ready=0 in INIT, 1 in RUN.
- Request accepted when state=RUN, refr=0, and read|write. Otherwise any read|write pulses drop the next cycle; no read_vld, no write.
- Write: mem[addr] <= din at end of cycle. addr >= WORDS: write discarded.
- Read: returns mem[addr] as of cycle start; read+write same cycle, same address: old data returned, new data stored.
- Read addr >= WORDS: read_vld=1, dout=0, read_derr=1, read_serr=0.
- Error injection (sampled with read): inj_derr -> dout = data with bit 0 inverted, read_derr=1, read_serr=0; inj_serr only -> dout = true data, read_serr=1; both -> derr behaviour. Flags apply only to that response.
- Refresh (REFR_PERIOD>0): cycle counter runs only in RUN, starts 0 on INIT->RUN; refr=1 for the one cycle the counter equals REFR_PERIOD-1, counter wraps to 0.
- Reset mid-operation: all in-flight responses discarded; no read_vld after reset, array re-cleared.

## Timing
- Reset values (cycle after rst=0 sampled): read_vld=0, read_serr=0, read_derr=0, dout=0, ready=0, refr=0, drop=0.
- First cycle with rst=1 is INIT cycle 0; ready=1 from cycle WORDS.
- Read accepted in cycle T -> read_vld, flags, dout valid in cycle T+LATENCY. LATENCY=0: combinational same cycle.
- Pipeline carries vld/serr/derr/data through LATENCY stages; one request per cycle, back-to-back reads return back-to-back.
- When read_vld=0, dout holds last value; read_serr/read_derr are 0.
- drop asserted in cycle T+1 for an ignored request in cycle T.
- Write in cycle T visible to reads accepted in cycle T+1 onward.

## Test plan
- Reset release, WORDS=256: ready=0 cycles 0..255, ready=1 at cycle 256; read of addr 0x10 returns 0 with read_vld at LATENCY.
- LATENCY=3: write 0xDEADBEEF to 0x05 cycle T, read 0x05 cycle T+1 -> read_vld=1, dout=0xDEADBEEF in cycle T+4; eight back-to-back reads return eight consecutive valid cycles.
- Same-cycle read+write addr 0x07 (old 0x11, new 0x22): response 0x11; later read returns 0x22.
- Read 0x07 (data 0x22) with inj_serr -> dout=0x22, serr=1; with inj_derr -> dout=0x23, derr=1; both -> dout=0x23, derr=1, serr=0. Read addr 0x100 (WORDS=256, AW=9) -> dout=0, derr=1.
- REFR_PERIOD=16: refr pulses every 16 cycles in RUN; read in refr cycle -> drop=1 next cycle, no read_vld; read during INIT likewise dropped.
- LATENCY=5: issue reads, assert rst=0 two cycles later for one cycle -> no read_vld ever, ready=0, INIT restarts and completes after WORDS cycles.
